// File: rtl/add.sv
// Rational cross-product stage: s_num/s_den = (l_num*r_den)/(l_den*r_num), one-cycle latency.
// Optional overflow flag output ovf is built when RAT_OVF_EN is defined.
module add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den
`ifdef RAT_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Without the flag the upper product half is never observed, so only the low half is formed.
`ifdef RAT_OVF_EN
    localparam int unsigned PW = 2 * WIDTH;
`else
    localparam int unsigned PW = WIDTH;
`endif

    logic [PW-1:0]    w_prod_num;
    logic [PW-1:0]    w_prod_den;
    logic [WIDTH-1:0] r_s_num;
    logic [WIDTH-1:0] r_s_den;

    assign w_prod_num = PW'(l_num) * PW'(r_den);
    assign w_prod_den = PW'(l_den) * PW'(r_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_num <= '0;
            r_s_den <= '0;
        end else begin
            r_s_num <= w_prod_num[WIDTH-1:0];
            r_s_den <= w_prod_den[WIDTH-1:0];
        end
    end

    assign s_num = r_s_num;
    assign s_den = r_s_den;

`ifdef RAT_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Either truncated product losing information raises the flag.
    assign w_ovf = (|w_prod_num[PW-1:WIDTH]) | (|w_prod_den[PW-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_add.sv
// Self-checking bench for add: directed vector table, hold/reset sequences, randomized model checks.
// Checks ovf as well when RAT_OVF_EN is defined.
module tb_add;

    logic        clk;
    logic        rst;
    logic [31:0] l_num, l_den, r_num, r_den;
    logic [31:0] s_num, s_den;
`ifdef RAT_OVF_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    add #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .l_num (l_num),
        .l_den (l_den),
        .r_num (r_num),
        .r_den (r_den),
        .s_num (s_num),
        .s_den (s_den)
`ifdef RAT_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rs;
        logic [31:0] ln, ld, rn, rd;
        logic [31:0] en, ed;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] en, input logic [31:0] ed,
                           input logic eo);
        chk({name, ".num"}, s_num, en);
        chk({name, ".den"}, s_den, ed);
`ifdef RAT_OVF_EN
        chk({name, ".ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) begin end
`endif
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic rs, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        @(negedge clk);
        rst = rs; l_num = a; l_den = b; r_num = c; r_den = d;
        @(posedge clk);
        #1;
    endtask

    // Reference: exact cross products in 64-bit arithmetic, result kept mod 2^32.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, output logic [31:0] en, output logic [31:0] ed,
                         output logic eo);
        longint unsigned pn, pd;
        pn = longint'(a) * longint'(d);
        pd = longint'(b) * longint'(c);
        en = 32'(pn % 64'h1_0000_0000);
        ed = 32'(pd % 64'h1_0000_0000);
        eo = (pn >= 64'h1_0000_0000) || (pd >= 64'h1_0000_0000);
    endtask

    task automatic add_vec(input string n, input logic rs, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c, input logic [31:0] d,
                           input logic [31:0] en, input logic [31:0] ed, input logic eo);
        vec_t v;
        v.name = n; v.rs = rs; v.ln = a; v.ld = b; v.rn = c; v.rd = d;
        v.en = en; v.ed = ed; v.eo = eo;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] a, b, c, d, en, ed;
        logic        eo;

        rst = 1'b1; l_num = '0; l_den = '0; r_num = '0; r_den = '0;

        add_vec("reset0",     1, 32'd7, 32'd8, 32'd9, 32'd10, 0, 0, 0);
        add_vec("reset1",     1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd5, 0, 0, 0);
        add_vec("basic",      0, 32'd3, 32'd4, 32'd5, 32'd7, 32'd21, 32'd20, 0);
        add_vec("zeros",      0, 32'd0, 32'd9, 32'd0, 32'd6, 0, 0, 0);
        add_vec("pipe_n",     0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 32'd6, 0);
        add_vec("pipe_n1",    0, 32'd10, 32'd20, 32'd30, 32'd40, 32'd400, 32'd600, 0);
        add_vec("trunc",      0, 32'h10000, 32'd1, 32'd1, 32'h10000, 32'd0, 32'd1, 1);
        add_vec("no_trunc",   0, 32'hFFFF, 32'd1, 32'd1, 32'hFFFF, 32'hFFFE_0001, 32'd1, 0);
        add_vec("rnum_zero",  0, 32'd5, 32'd6, 32'd0, 32'd7, 32'd35, 32'd0, 0);
        add_vec("lden_zero",  0, 32'd5, 32'd0, 32'd8, 32'd7, 32'd35, 32'd0, 0);
        add_vec("den_trunc",  0, 32'd2, 32'h8000_0000, 32'd2, 32'd3, 32'd6, 32'd0, 1);
        add_vec("max",        0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        add_vec("midreset",   1, 32'd11, 32'd12, 32'd13, 32'd14, 0, 0, 0);
        add_vec("post_reset", 0, 32'd2, 32'd3, 32'd4, 32'd5, 32'd10, 32'd12, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rs, vecs[i].ln, vecs[i].ld, vecs[i].rn, vecs[i].rd);
            chk_out(vecs[i].name, vecs[i].en, vecs[i].ed, vecs[i].eo);
        end

        // Outputs must hold while inputs change mid-cycle, then update on the next edge.
        apply(0, 32'd6, 32'd1, 32'd7, 32'd1);
        chk_out("hold_a", 32'd6, 32'd7, 0);
        @(negedge clk);
        l_num = 32'd2; l_den = 32'd3; r_num = 32'd4; r_den = 32'd5;
        #1;
        chk_out("hold_mid", 32'd6, 32'd7, 0);
        @(posedge clk);
        #1;
        chk_out("hold_b", 32'd10, 32'd12, 0);

        // Reset held for several cycles keeps outputs at zero regardless of inputs.
        for (int k = 0; k < 3; k++) begin
            apply(1, $urandom, $urandom, $urandom, $urandom);
            chk_out("reset_hold", 0, 0, 0);
        end

        for (int k = 0; k < 1000; k++) begin
            a = $urandom_range(0, 999); b = $urandom_range(0, 999);
            c = $urandom_range(0, 999); d = $urandom_range(0, 999);
            apply(0, a, b, c, d);
            model(a, b, c, d, en, ed, eo);
            chk_out("rand_small", en, ed, eo);
        end

        for (int k = 0; k < 200; k++) begin
            a = $urandom; b = $urandom; c = $urandom; d = $urandom;
            if (k % 4 == 0) begin
                a = a >> 16; d = d >> 16;
            end
            apply(0, a, b, c, d);
            model(a, b, c, d, en, ed, eo);
            chk_out("rand_full", en, ed, eo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
